// File: rtl/pingpong_accum_sched_pkg.sv
// Shared types and defaults for the ping-pong complex accumulator scheduler.
// Complex words are packed {real, imag}, with each half stored in two's complement.
package pingpong_accum_sched_pkg;

    localparam int WIDTH_DEF = 48;
    localparam int CNT_W_DEF = 8;
    localparam int HALF_DEF  = WIDTH_DEF / 2;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_ACCUM = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_e;

    function automatic logic [WIDTH_DEF-1:0] cplx_pack(input logic [HALF_DEF-1:0] re,
                                                       input logic [HALF_DEF-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [HALF_DEF-1:0] cplx_re(input logic [WIDTH_DEF-1:0] x);
        return x[WIDTH_DEF-1:HALF_DEF];
    endfunction

    function automatic logic [HALF_DEF-1:0] cplx_im(input logic [WIDTH_DEF-1:0] x);
        return x[HALF_DEF-1:0];
    endfunction

endpackage

// File: rtl/pingpong_accum_sched_if.sv
// Sample-in / result-out handshake bundle for the ping-pong accumulator.
interface pingpong_accum_sched_if
    import pingpong_accum_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_bank;
    logic [CNT_W-1:0] out_cnt;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_bank, out_cnt, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_bank, out_cnt, out_valid
    );
endinterface

// File: rtl/pingpong_accum_sched_addsub.sv
// Complex adder/subtractor: each half wraps independently, so no carry crosses from imag into real.
module addsub_cplx
    import pingpong_accum_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             mode,
    output logic [WIDTH-1:0] out
);
    localparam int HALF = WIDTH / 2;

    logic [HALF-1:0] re_res;
    logic [HALF-1:0] im_res;

    always_comb begin
        if (mode) begin
            re_res = in1[WIDTH-1:HALF] - in2[WIDTH-1:HALF];
            im_res = in1[HALF-1:0]     - in2[HALF-1:0];
        end else begin
            re_res = in1[WIDTH-1:HALF] + in2[WIDTH-1:HALF];
            im_res = in1[HALF-1:0]     + in2[HALF-1:0];
        end
    end

    assign out = {re_res, im_res};
endmodule

// File: rtl/pingpong_accum_sched.sv
// Two-bank ping-pong complex accumulator: one bank fills while the other waits to drain.
// Results leave in fill order; input stalls only while the active bank still holds a result.
module pingpong_accum_sched
    import pingpong_accum_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [CNT_W-1:0] cfg_len,
    pingpong_accum_sched_if.slave bus
);
    bank_state_e      state_reg [2];
    logic [WIDTH-1:0] acc_reg   [2];
    logic [CNT_W-1:0] cnt_reg   [2];
    logic [CNT_W-1:0] len_reg   [2];
    logic             act_ptr_reg;
    logic             out_ptr_reg;

    logic [1:0] close_vec;
    logic [1:0] drain_vec;
    logic       accept;
    logic       out_hs;

    // in_ready looks only at registered state, so a drain frees the bank one cycle later.
    assign bus.in_ready  = en && !reset && (state_reg[act_ptr_reg] != BANK_FULL);
    assign bus.out_valid = (state_reg[out_ptr_reg] == BANK_FULL);
    assign bus.out_data  = acc_reg[out_ptr_reg];
    assign bus.out_bank  = out_ptr_reg;
    assign bus.out_cnt   = cnt_reg[out_ptr_reg];

    assign accept = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [WIDTH-1:0] sum;
            logic             is_act;
            logic             load;
            logic             first;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] len_eff;

            addsub_cplx #(.WIDTH(WIDTH)) u_add (
                .in1  (bus.in_data),
                .in2  (acc_reg[gi]),
                .mode (1'b0),
                .out  (sum)
            );

            assign is_act   = (act_ptr_reg == 1'(gi));
            assign load     = accept && is_act;
            assign first    = (state_reg[gi] == BANK_EMPTY);
            assign cnt_next = first ? CNT_W'(1) : cnt_reg[gi] + CNT_W'(1);
            // Frame length is captured at the first sample; a zero length behaves as one.
            assign len_eff  = first ? ((cfg_len == '0) ? CNT_W'(1) : cfg_len) : len_reg[gi];

            assign close_vec[gi] = is_act &&
                ((load && ((cnt_next == len_eff) || flush)) ||
                 (!load && flush && (state_reg[gi] == BANK_ACCUM)));
            assign drain_vec[gi] = out_hs && (out_ptr_reg == 1'(gi));

            always_ff @(posedge clock) begin
                if (reset) begin
                    state_reg[gi] <= BANK_EMPTY;
                    acc_reg[gi]   <= '0;
                    cnt_reg[gi]   <= '0;
                    len_reg[gi]   <= '0;
                end else begin
                    if (load) begin
                        acc_reg[gi] <= first ? bus.in_data : sum;
                        cnt_reg[gi] <= cnt_next;
                        len_reg[gi] <= len_eff;
                    end
                    if (close_vec[gi]) begin
                        state_reg[gi] <= BANK_FULL;
                    end else if (load) begin
                        state_reg[gi] <= BANK_ACCUM;
                    end else if (drain_vec[gi]) begin
                        state_reg[gi] <= BANK_EMPTY;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            act_ptr_reg <= 1'b0;
            out_ptr_reg <= 1'b0;
        end else begin
            if (|close_vec) act_ptr_reg <= ~act_ptr_reg;
            if (|drain_vec) out_ptr_reg <= ~out_ptr_reg;
        end
    end
endmodule
